tiny_mips: RTL and testbench



---
 rtl/tiny_mips_pkg.sv | 58 +++++
 rtl/tiny_mips_alu.sv | 34 +++
 rtl/tiny_mips.sv | 130 +++++++++++++
 tb/tb_tiny_mips.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_mips_pkg.sv
// Shared definitions for the TinyMIPS core: widths, instruction field positions,
// opcodes, FSM state encoding and small decode helpers.
// Build option: TINYMIPS_MUL_EN enables the MUL opcode (0010); otherwise it is a NOP.
package tiny_mips_pkg;

    localparam int unsigned DataW   = 16;
    localparam int unsigned NumRegs = 8;
    localparam int unsigned RegIdxW = 3;

    // Instruction field positions
    localparam int unsigned OpHi   = 15;
    localparam int unsigned OpLo   = 12;
    localparam int unsigned RaHi   = 11;
    localparam int unsigned RaLo   = 9;
    localparam int unsigned RbHi   = 8;
    localparam int unsigned RbLo   = 6;
    localparam int unsigned RcHi   = 5;
    localparam int unsigned RcLo   = 3;
    localparam int unsigned Imm6Hi = 5;
    localparam int unsigned Imm9Hi = 8;

    // Opcodes
    localparam logic [3:0] OpWait = 4'h0;
    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpMul  = 4'h2;
    localparam logic [3:0] OpAdd  = 4'h3;
    localparam logic [3:0] OpNand = 4'h4;
    localparam logic [3:0] OpSrl  = 4'h5;
    localparam logic [3:0] OpCp   = 4'h6;
    localparam logic [3:0] OpCpi  = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpBlt  = 4'h9;
    localparam logic [3:0] OpLd   = 4'hA;
    localparam logic [3:0] OpSt   = 4'hB;

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StDecode = 2'd1,
        StExec   = 2'd2,
        StMem    = 2'd3
    } state_t;

    function automatic logic [DataW-1:0] sext6(input logic [5:0] v);
        return {{(DataW - 6){v[5]}}, v};
    endfunction

    // Opcodes whose EXEC cycle writes the ALU result into rA
    function automatic logic writes_rf(input logic [3:0] op);
        case (op)
            OpAddi, OpAdd, OpNand, OpSrl, OpCp, OpCpi: return 1'b1;
`ifdef TINYMIPS_MUL_EN
            OpMul: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tiny_mips_alu.sv
// Combinational ALU for the TinyMIPS core: arithmetic/logic result and branch decision.
// Build option: TINYMIPS_MUL_EN adds the 16x16 multiplier for opcode 0010.
module tiny_mips_alu
    import tiny_mips_pkg::*;
(
    input  logic [3:0]       op_i,
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  logic [DataW-1:0] imm_i,
    output logic [DataW-1:0] result_o,
    output logic             taken_o
);

    // Decode opcode into a result word and a branch-taken flag
    always_comb begin
        result_o = '0;
        taken_o  = 1'b0;
        case (op_i)
            OpAddi: result_o = a_i + imm_i;
`ifdef TINYMIPS_MUL_EN
            OpMul:  result_o = a_i * b_i;
`endif
            OpAdd:  result_o = a_i + b_i;
            OpNand: result_o = ~(a_i & b_i);
            OpSrl:  result_o = a_i >> b_i[3:0];
            OpCp:   result_o = a_i;
            OpCpi:  result_o = imm_i;
            OpBeq:  taken_o  = (a_i == b_i);
            OpBlt:  taken_o  = (a_i < b_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/tiny_mips.sv
// TinyMIPS multicycle core: FETCH/DECODE/EXEC/MEM FSM, PC, IR and an 8x16 register
// file sharing one synchronous single-port RAM for instructions and data.
// Build option: TINYMIPS_MUL_EN enables MUL (see tiny_mips_alu / tiny_mips_pkg).
module tiny_mips
    import tiny_mips_pkg::*;
#(
    parameter int unsigned SIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DataW-1:0] data_fromRAM,
    output logic             wrEn,
    output logic [SIZE-1:0]  addr_toRAM,
    output logic [DataW-1:0] data_toRAM
);

    state_t           st, st_d;
    logic [SIZE-1:0]  PC, pc_d;
    logic [DataW-1:0] ir_q, ir_d;
    logic [DataW-1:0] RF [0:NumRegs-1];

    logic               rf_we;
    logic [RegIdxW-1:0] rf_waddr;
    logic [DataW-1:0]   rf_wdata;

    logic [3:0]         op;
    logic [RegIdxW-1:0] ra, rb, rc;
    logic [DataW-1:0]   imm6_sx, imm9_zx;
    logic               is_branch;
    logic [DataW-1:0]   alu_a, alu_b, alu_imm, alu_res;
    logic               alu_taken;
    logic [SIZE-1:0]    mem_addr, pc_inc, pc_br;

    assign op        = ir_q[OpHi:OpLo];
    assign ra        = ir_q[RaHi:RaLo];
    assign rb        = ir_q[RbHi:RbLo];
    assign rc        = ir_q[RcHi:RcLo];
    assign imm6_sx   = sext6(ir_q[Imm6Hi:0]);
    assign imm9_zx   = {{(DataW - 9){1'b0}}, ir_q[Imm9Hi:0]};
    assign is_branch = (op == OpBeq) || (op == OpBlt);

    // Branches compare rA/rB; everything else operates on rB/rC
    assign alu_a   = is_branch ? RF[ra] : RF[rb];
    assign alu_b   = is_branch ? RF[rb] : RF[rc];
    assign alu_imm = (op == OpCpi) ? imm9_zx : imm6_sx;

    // Effective address uses only the low byte of rB
    assign mem_addr = SIZE'({8'h00, RF[rb][7:0]} + imm6_sx);
    assign pc_inc   = PC + SIZE'(1);
    assign pc_br    = PC + SIZE'(imm6_sx);

    tiny_mips_alu u_alu (
        .op_i     (op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .imm_i    (alu_imm),
        .result_o (alu_res),
        .taken_o  (alu_taken)
    );

    // State, PC, IR and register file updates; async reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= StFetch;
            PC   <= '0;
            ir_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                RF[i] <= '0;
            end
        end else begin
            st   <= st_d;
            PC   <= pc_d;
            ir_q <= ir_d;
            if (rf_we) begin
                RF[rf_waddr] <= rf_wdata;
            end
        end
    end

    // Next-state logic and RAM-port outputs
    always_comb begin
        st_d       = st;
        pc_d       = PC;
        ir_d       = ir_q;
        rf_we      = 1'b0;
        rf_waddr   = ra;
        rf_wdata   = alu_res;
        wrEn       = 1'b0;
        addr_toRAM = PC;
        data_toRAM = '0;
        unique case (st)
            StFetch: begin
                st_d = StDecode;
            end
            StDecode: begin
                ir_d = data_fromRAM;
                st_d = StExec;
            end
            StExec: begin
                st_d = StFetch;
                pc_d = pc_inc;
                if (op == OpLd) begin
                    addr_toRAM = mem_addr;
                    pc_d       = PC;
                    st_d       = StMem;
                end else if (op == OpSt) begin
                    addr_toRAM = mem_addr;
                    data_toRAM = RF[ra];
                    wrEn       = ~rst;
                end else if (ir_q == '0) begin
                    // WAIT: re-fetch the same word until memory changes it
                    pc_d = PC;
                end else if (is_branch) begin
                    if (alu_taken) begin
                        pc_d = pc_br;
                    end
                end else begin
                    rf_we = writes_rf(op);
                end
            end
            StMem: begin
                rf_we    = 1'b1;
                rf_wdata = data_fromRAM;
                pc_d     = pc_inc;
                st_d     = StFetch;
            end
        endcase
    end

endmodule

// File: tb/tb_tiny_mips.sv
// Directed self-checking bench for tiny_mips with a behavioural 256x16 block RAM.
module tb_tiny_mips;

    localparam logic [3:0] OpAddi = 4'h1;
    localparam logic [3:0] OpMul  = 4'h2;
    localparam logic [3:0] OpAdd  = 4'h3;
    localparam logic [3:0] OpNand = 4'h4;
    localparam logic [3:0] OpSrl  = 4'h5;
    localparam logic [3:0] OpCp   = 4'h6;
    localparam logic [3:0] OpCpi  = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpBlt  = 4'h9;
    localparam logic [3:0] OpLd   = 4'hA;
    localparam logic [3:0] OpSt   = 4'hB;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_fromRAM;
    logic        wrEn;
    logic [7:0]  addr_toRAM;
    logic [15:0] data_toRAM;

    logic [15:0] mem [0:255];
    logic        tb_we  = 1'b0;
    logic        tb_clr = 1'b0;
    logic [7:0]  tb_addr;
    logic [15:0] tb_wdata;
    int          wr_cnt = 0;

    int total = 0;
    int bad   = 0;

    tiny_mips #(.SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_fromRAM (data_fromRAM),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM)
    );

    always #5 clk = ~clk;

    // Behavioural block RAM with a bench-side load/clear port
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_wdata;
        end else if (wrEn) begin
            mem[addr_toRAM] <= data_toRAM;
        end
        data_fromRAM <= mem[addr_toRAM];
    end

    always @(negedge clk) if (wrEn === 1'b1) wr_cnt <= wr_cnt + 1;

    function automatic logic [15:0] enc3(input logic [3:0] op, input int a, input int b,
                                         input int c);
        return {op, a[2:0], b[2:0], c[2:0], 3'b000};
    endfunction

    function automatic logic [15:0] enci(input logic [3:0] op, input int a, input int b,
                                         input int imm);
        return {op, a[2:0], b[2:0], imm[5:0]};
    endfunction

    function automatic logic [15:0] enc9(input logic [3:0] op, input int a, input int imm);
        return {op, a[2:0], imm[8:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        tb_we = 1'b1;
        tb_addr = a[7:0];
        tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic reset_clear();
        rst = 1'b1;
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_until_pc(input int target, input int max, output int cyc);
        cyc = 0;
        while (dut.PC !== target[7:0] && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int c;
    int wr0;
    logic [15:0] exp_r2, exp_r5;

    initial begin
        rst = 1'b1;
        // Reset with memory all zero
        reset_clear();
        repeat (8) @(negedge clk);
        chk("rst_pc", dut.PC, 0);
        chk("rst_st", dut.st, 0);
        chk("rst_wren", wrEn, 0);
        chk("rst_addr", addr_toRAM, 0);
        chk("rst_data", data_toRAM, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("wait_pc", dut.PC, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("wait_rf%0d", i), dut.RF[i], 0);

        // Factorial loaded while spinning in WAIT; word 0 last so it starts cleanly
        poke(5, enci(OpBlt, 1, 3, -2));
        poke(4, enci(OpAddi, 1, 1, 1));
        poke(3, enc3(OpMul, 2, 2, 1));
        poke(2, enc9(OpCpi, 3, 6));
        poke(1, enci(OpCp, 2, 1, 0));
        poke(0, enc9(OpCpi, 1, 1));
        run_until_pc(6, 130, c);
        chk("fact_in_time", (c < 130), 1);
        repeat (12) @(negedge clk);
`ifdef TINYMIPS_MUL_EN
        exp_r2 = 16'd120;
`else
        exp_r2 = 16'd1;
`endif
        chk("fact_pc_park", dut.PC, 6);
        chk("fact_r1", dut.RF[1], 6);
        chk("fact_r2", dut.RF[2], exp_r2);
        chk("fact_r3", dut.RF[3], 6);

        // ADD / LD latency and results
        reset_clear();
        poke(0, enc9(OpCpi, 1, 3));
        poke(1, enc9(OpCpi, 2, 4));
        poke(2, enc3(OpAdd, 5, 1, 2));
        poke(3, enc9(OpCpi, 1, 1));
        poke(4, enci(OpLd, 4, 1, 31));
        poke(5, enci(OpLd, 6, 1, -32));
        poke(8'h20, 16'hBEEF);
        poke(8'hE1, 16'h5A5A);
        rst = 1'b0;
        run_until_pc(2, 20, c);
        chk("cpi_x2_cycles", c, 6);
        run_until_pc(3, 20, c);
        chk("add_cycles", c, 3);
        run_until_pc(4, 20, c);
        run_until_pc(5, 20, c);
        chk("ld_cycles", c, 4);
        run_until_pc(6, 20, c);
        repeat (8) @(negedge clk);
        chk("add_r5", dut.RF[5], 16'd7);
        chk("ld_r4", dut.RF[4], 16'hBEEF);
        chk("ld_neg_wrap_r6", dut.RF[6], 16'h5A5A);
        chk("ld_pc_park", dut.PC, 6);

        // Store with single-cycle write strobe
        reset_clear();
        poke(0, enc9(OpCpi, 0, 9'h010));
        poke(1, enc9(OpCpi, 6, 9'h123));
        for (int i = 2; i < 6; i++) poke(i, enc3(OpAdd, 6, 6, 6));
        poke(6, enci(OpAddi, 6, 6, 4));
        poke(7, enci(OpSt, 6, 0, 1));
        wr0 = wr_cnt;
        rst = 1'b0;
        run_until_pc(8, 60, c);
        repeat (6) @(negedge clk);
        chk("st_r6", dut.RF[6], 16'h1234);
        chk("st_mem11", mem[8'h11], 16'h1234);
        chk("st_mem10", mem[8'h10], 16'h0000);
        chk("st_wren_cycles", wr_cnt - wr0, 1);
        chk("st_pc_park", dut.PC, 8);

        // BEQ backwards from address 0 wraps to 255
        reset_clear();
        poke(0, enci(OpBeq, 0, 0, -1));
        rst = 1'b0;
        run_until_pc(255, 20, c);
        chk("beq_cycles", c, 3);
        repeat (6) @(negedge clk);
        chk("beq_wrap_pc", dut.PC, 255);

        // BLT equal not taken, CPi max imm9, ADDi wrap
        reset_clear();
        poke(0, enc9(OpCpi, 1, 5));
        poke(1, enc9(OpCpi, 2, 5));
        poke(2, enci(OpBlt, 1, 2, 3));
        poke(3, enc9(OpCpi, 7, 511));
        poke(4, enci(OpAddi, 3, 0, -1));
        poke(5, enci(OpAddi, 4, 3, 1));
        rst = 1'b0;
        run_until_pc(6, 60, c);
        repeat (6) @(negedge clk);
        chk("blt_eq_r7", dut.RF[7], 16'h01FF);
        chk("addi_neg_r3", dut.RF[3], 16'hFFFF);
        chk("addi_wrap_r4", dut.RF[4], 16'h0000);
        chk("blt_pc_park", dut.PC, 6);

        // NAND, SRL (uses rC[3:0]), NOPs, MUL, CP
        reset_clear();
        poke(0, enc9(OpCpi, 1, 9'h0F0));
        poke(1, enc9(OpCpi, 2, 9'h014));
        poke(2, enc3(OpNand, 3, 1, 1));
        poke(3, enc3(OpSrl, 4, 3, 2));
        poke(4, 16'hC000);
        poke(5, 16'h0001);
        poke(6, enc3(OpMul, 5, 3, 2));
        poke(7, enci(OpCp, 7, 4, 0));
        rst = 1'b0;
        run_until_pc(8, 60, c);
        repeat (6) @(negedge clk);
`ifdef TINYMIPS_MUL_EN
        exp_r5 = 16'hED2C;
`else
        exp_r5 = 16'h0000;
`endif
        chk("nand_r3", dut.RF[3], 16'hFF0F);
        chk("srl_r4", dut.RF[4], 16'h0FF0);
        chk("mul_r5", dut.RF[5], exp_r5);
        chk("cp_r7", dut.RF[7], 16'h0FF0);
        chk("logic_pc_park", dut.PC, 8);

        // Reset during EXEC of a store suppresses the write
        reset_clear();
        poke(0, enc9(OpCpi, 0, 9'h010));
        poke(1, enc9(OpCpi, 6, 9'h055));
        poke(2, enci(OpSt, 6, 0, 1));
        rst = 1'b0;
        c = 0;
        while (!(dut.PC === 8'd2 && dut.st === 2'd2) && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("st_exec_reached", (c < 40), 1);
        chk("st_exec_wren", wrEn, 1);
        rst = 1'b1;
        #1;
        chk("midrst_wren", wrEn, 0);
        @(negedge clk);
        chk("midrst_mem11", mem[8'h11], 16'h0000);
        chk("midrst_pc", dut.PC, 0);
        chk("midrst_st", dut.st, 0);
        chk("midrst_r0", dut.RF[0], 0);
        chk("midrst_r6", dut.RF[6], 0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
